// File: rtl/led_envelope.sv
// LED brightness envelope: attack/hold/decay ramp driven by GATE,
// converted to a glitch-free PWM output whose duty updates once per PWM period.
module led_envelope #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 16
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             GATE,
    input  logic [WIDTH-1:0] ATTACK_STEP,
    input  logic [WIDTH-1:0] DECAY_STEP,
    output logic [WIDTH-1:0] LEVEL,
    output logic             PWM,
    output logic             BUSY
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, ATTACK, HOLD, DECAY} state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [PW-1:0]    r_pre;
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] w_level_nx;
    logic [WIDTH-1:0] r_pcnt;
    logic [WIDTH-1:0] r_duty;
    logic             r_pwm;
    logic             w_tick;
    logic [WIDTH:0]   w_sum;

    assign w_tick = (r_pre == PLAST);
    assign w_sum  = {1'b0, r_level} + {1'b0, ATTACK_STEP};

    // A gate-driven transition wins over a level step in the same cycle.
    always_comb begin
        w_state_nx = r_state;
        w_level_nx = r_level;
        unique case (r_state)
            IDLE: begin
                w_level_nx = '0;
                if (GATE) w_state_nx = ATTACK;
            end
            ATTACK: begin
                if (!GATE) begin
                    w_state_nx = DECAY;
                end else if (w_tick) begin
                    w_level_nx = w_sum[WIDTH] ? MAX : w_sum[WIDTH-1:0];
                    if (w_level_nx == MAX) w_state_nx = HOLD;
                end
            end
            HOLD: begin
                w_level_nx = MAX;
                if (!GATE) w_state_nx = DECAY;
            end
            DECAY: begin
                if (GATE) begin
                    w_state_nx = ATTACK;
                end else if (w_tick) begin
                    w_level_nx = (DECAY_STEP >= r_level) ? '0
                                 : r_level - DECAY_STEP;
                    if (w_level_nx == '0) w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_level_nx = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (R) begin
            r_state <= IDLE;
            r_level <= '0;
            r_pre   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_level <= w_level_nx;
            r_pre   <= w_tick ? '0 : r_pre + 1'b1;
        end
    end

    // Duty only reloads at the period boundary, so no runt pulses.
    always_ff @(posedge CLK) begin
        if (R) begin
            r_pcnt <= '0;
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
            if (r_pcnt == MAX) r_duty <= r_level;
            r_pwm  <= (r_duty == MAX) | (r_pcnt < r_duty);
        end
    end

    assign LEVEL = r_level;
    assign PWM   = r_pwm;
    assign BUSY  = (r_state != IDLE);

endmodule

// File: doc/led_envelope.md
Name: led_envelope

Overview:
- Downstream stage of the S/R one-shot timers: consumes a timer's OUT as GATE and drives an LED.
- Produces a brightness envelope: ramps up while GATE is high, holds at full scale, and ramps down when GATE falls.
- Converts the brightness to a glitch-free PWM output. One instance per LED channel.

Parameters:
WIDTH, 8, brightness and PWM resolution in bits; MAX = 2^WIDTH-1
PRESCALE, 16, clocks per envelope step tick (>=1)

Ports:
CLK  input  1  system clock, all logic on rising edge
R  input  1  synchronous active-high reset
GATE  input  1  envelope gate, typically a sr_timer OUT; level-sensitive
ATTACK_STEP  input  WIDTH  brightness increment per tick in ATTACK
DECAY_STEP  input  WIDTH  brightness decrement per tick in DECAY
LEVEL  output  WIDTH  current envelope brightness (registered)
PWM  output  1  LED drive (registered)
BUSY  output  1  high whenever state != IDLE

Behaviour:
- Interface: one clock (CLK); reset R is synchronous and active-high.
- Reset (R=1 at a CLK edge) overrides everything, including mid-ramp. State=IDLE; LEVEL=0, PWM=0, BUSY=0; prescaler, PWM counter and duty register all 0.
- Prescaler: free-running counter 0..PRESCALE-1. TICK is high for the one cycle when the counter equals PRESCALE-1; the counter then wraps to 0. With PRESCALE=1, TICK is high every cycle.
- IDLE: LEVEL held at 0. GATE=1 moves to ATTACK on the next edge.
- ATTACK:
  - GATE=0 moves to DECAY, starting from the current LEVEL.
  - Otherwise, on TICK: LEVEL = min(LEVEL+ATTACK_STEP, MAX). Compute the sum at WIDTH+1 bits and saturate.
  - If the new LEVEL==MAX, the state becomes HOLD on the same edge.
- HOLD: LEVEL=MAX. GATE=0 moves to DECAY.
- DECAY:
  - GATE=1 moves to ATTACK (retrigger from the current LEVEL, no reset to 0).
  - Otherwise, on TICK: LEVEL = max(LEVEL-DECAY_STEP, 0), with a borrow-checked subtract.
  - If the new LEVEL==0, the state becomes IDLE on the same edge.
- Priority: a GATE-driven state change in a cycle suppresses the LEVEL step in that cycle, even if TICK=1.
- Step value 0: no LEVEL progress; the state persists until GATE changes. This is legal, not an error.
- Step inputs are sampled on each TICK and may change at any time.
- BUSY: combinational decode of the state register (state != IDLE). It goes high the cycle after the IDLE->ATTACK edge and low the cycle after DECAY->IDLE.
- PWM counter PCNT: WIDTH bits, free-running 0..MAX, wraps to 0.
- Duty register DUTY: loaded from LEVEL only on the edge where PCNT==MAX, so the new duty applies from the PCNT=0 period onward. Mid-period LEVEL changes never produce runt pulses.
- PWM output (registered):
  - DUTY==MAX gives PWM=1 constantly.
  - Otherwise PWM = (PCNT < DUTY), so it is high for exactly DUTY clocks of every 2^WIDTH.
  - DUTY=0 gives PWM=0 constantly.
- PWM latency: one clock from PCNT/DUTY to the PWM pin. The first period after reset has DUTY=0.
- GATE is assumed synchronous to CLK; it is produced by sr_timer on the same clock, so no synchronizer is needed.

Test Plan:
- Reset: WIDTH=8, PRESCALE=4, R=1 for 3 cycles with GATE=1 -> LEVEL=0, PWM=0, BUSY=0 throughout; state ATTACK the edge after R falls.
- Attack saturation: GATE=1, ATTACK_STEP=64 -> LEVEL 64,128,192,255 on successive ticks 4 clocks apart; the 192+64 step saturates to 255; state HOLD; BUSY=1.
- Decay to idle: from HOLD, GATE=0, DECAY_STEP=100 -> LEVEL 155,55,0 on successive ticks; state IDLE when LEVEL reaches 0; BUSY=0 next cycle.
- Retrigger: in DECAY at LEVEL=155, GATE=1 -> no step that cycle; ATTACK; next tick LEVEL=219, following tick 255 then HOLD.
- PWM duty: hold LEVEL=64 across full periods -> PWM high exactly 64 of each 256 clocks, starting at PCNT=0 of the period after loading. A LEVEL change mid-period does not alter PWM until the next PCNT wrap. LEVEL=255 -> PWM constantly 1.
- Edge cases:
  - ATTACK_STEP=0 with GATE=1 -> LEVEL stays 0, state ATTACK, BUSY=1.
  - R pulse mid-DECAY at LEVEL=55 -> all outputs 0 next cycle; IDLE.
